// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan scheduler.
package sseg_pkg;

  // Default number of scanned digits on the FMC LED socket.
  localparam int N_DIG_DEF = 4;

  // Active-low segment bus with every segment (and dp) off.
  localparam logic [7:0] SEG_BLANK_N = 8'hFF;

  // Scan FSM: idle, blank guard at slot start, lit phase.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_ON
  } state_t;

endpackage

// File: rtl/sseg_pwm.sv
// Brightness PWM for the scan scheduler: a free-running counter that
// advances on lit-phase cycles, cleared at every slot start.
module sseg_pwm #(
  parameter int BRT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [BRT_W-1:0] brt,
  output logic             pwm_on
);

  logic [BRT_W-1:0] pwm_cnt;

  // PWM phase counter; clearing at slot start makes every slot start at phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (clr) begin
      pwm_cnt <= '0;
    end else if (inc) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // All-ones brightness is treated as 100 % so full code is never dimmed.
  assign pwm_on = (&brt) || (pwm_cnt < brt);

endmodule

// File: rtl/sseg_scan_sched.sv
// Scan scheduler for the multiplexed seven-segment display: time-shares the
// segment bus between digits with a blank guard at the start of each slot.
// Build option: define SSEG_PWM_EN to enable global brightness PWM; when it
// is undefined i_brt is ignored and digits are lit for the whole ON phase.
module sseg_scan_sched
  import sseg_pkg::*;
#(
  parameter int N_DIG    = N_DIG_DEF,
  parameter int SCAN_DIV = 100_000,
  parameter int GUARD    = 1_000,
  parameter int BRT_W    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [N_DIG-1:0][7:0] i_seg_n,
  input  logic [N_DIG-1:0]      i_blank_mask,
  input  logic [BRT_W-1:0]      i_brt,
  output logic [N_DIG-1:0]      o_ldsel,
  output logic [7:0]            o_sseg_n,
  output logic                  o_frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

  // A zero-length guard skips straight to the lit phase.
  localparam state_t SLOT_FIRST = (GUARD > 0) ? ST_GUARD : ST_ON;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] dig_idx, dig_idx_nxt;
  logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
  logic             slot_start;
  logic             slot_end;

  logic [7:0]       snap_seg;
  logic             snap_mask;
  logic             pwm_on;
  logic             lit;
  logic [N_DIG-1:0] dig_sel;

  // Scan FSM state, digit index and slot counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      dig_idx  <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dig_idx  <= dig_idx_nxt;
      slot_cnt <= slot_cnt_nxt;
    end
  end

  // Next-state: disable always wins and restarts from digit 0 with a full guard.
  always_comb begin
    state_nxt    = state;
    dig_idx_nxt  = dig_idx;
    slot_cnt_nxt = slot_cnt;
    slot_start   = 1'b0;
    slot_end     = 1'b0;
    if (!i_en) begin
      state_nxt    = ST_IDLE;
      dig_idx_nxt  = '0;
      slot_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt    = SLOT_FIRST;
          dig_idx_nxt  = '0;
          slot_cnt_nxt = '0;
          slot_start   = 1'b1;
        end
        ST_GUARD: begin
          slot_cnt_nxt = slot_cnt + 1'b1;
          if (slot_cnt == GUARD_LAST) begin
            state_nxt = ST_ON;
          end
        end
        ST_ON: begin
          if (slot_cnt == CNT_LAST) begin
            slot_end     = 1'b1;
            slot_start   = 1'b1;
            slot_cnt_nxt = '0;
            state_nxt    = SLOT_FIRST;
            dig_idx_nxt  = (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
          end else begin
            slot_cnt_nxt = slot_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef SSEG_PWM_EN
  logic [BRT_W-1:0] snap_brt;

  // Per-slot input snapshot so mid-slot input changes cannot tear the digit.
  always_ff @(posedge i_clk) begin
    if (slot_start) begin
      snap_seg  <= i_seg_n[dig_idx_nxt];
      snap_mask <= i_blank_mask[dig_idx_nxt];
      snap_brt  <= i_brt;
    end
  end

  sseg_pwm #(
    .BRT_W (BRT_W)
  ) u_pwm (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (slot_start || !i_en),
    .inc    (i_en && (state == ST_ON)),
    .brt    (snap_brt),
    .pwm_on (pwm_on)
  );
`else
  logic unused_brt;

  // Per-slot input snapshot so mid-slot input changes cannot tear the digit.
  always_ff @(posedge i_clk) begin
    if (slot_start) begin
      snap_seg  <= i_seg_n[dig_idx_nxt];
      snap_mask <= i_blank_mask[dig_idx_nxt];
    end
  end

  assign unused_brt = ^i_brt;
  assign pwm_on     = 1'b1;
`endif

  assign dig_sel = N_DIG'(1) << dig_idx;
  assign lit     = i_en && (state == ST_ON) && !snap_mask && pwm_on;

  // Registered pin drivers: blank unless lit; frame tick at the last slot's end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ldsel      <= '0;
      o_sseg_n     <= SEG_BLANK_N;
      o_frame_tick <= 1'b0;
    end else begin
      o_ldsel      <= lit ? dig_sel : '0;
      o_sseg_n     <= lit ? snap_seg : SEG_BLANK_N;
      o_frame_tick <= slot_end && (dig_idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_sseg_scan_sched.sv
// Self-checking bench for sseg_scan_sched (SCAN_DIV=8, GUARD=2, BRT_W=2).
// Expectations follow SSEG_PWM_EN the same way the design build does.
module tb_sseg_scan_sched;

  localparam int N_DIG    = 4;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int BRT_W    = 2;
  localparam int FRAME    = N_DIG * SCAN_DIV;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [N_DIG-1:0][7:0] seg_n;
  logic [N_DIG-1:0]      mask;
  logic [BRT_W-1:0]      brt;
  logic [N_DIG-1:0]      ldsel;
  logic [7:0]            sseg_n;
  logic                  tick;

  sseg_scan_sched #(
    .N_DIG    (N_DIG),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD),
    .BRT_W    (BRT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_seg_n      (seg_n),
    .i_blank_mask (mask),
    .i_brt        (brt),
    .o_ldsel      (ldsel),
    .o_sseg_n     (sseg_n),
    .o_frame_tick (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_DIG-1:0] ldsel;
    logic [7:0]       sseg;
    logic             tick;
  } exp_t;

  typedef struct {
    logic [N_DIG-1:0] mask;
    logic [BRT_W-1:0] brt;
    int               exp_lit;
    int               exp_tick;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position p counts cycles since the enable was sampled.
  bit               active = 1'b0;
  int               p = 0;
  logic [7:0]       m_seg;
  logic             m_mask;
  logic [BRT_W-1:0] m_brt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit pwm_ok(input int j, input logic [BRT_W-1:0] b);
`ifdef SSEG_PWM_EN
    return (b == '1) || ((j % (1 << BRT_W)) < int'(b));
`else
    return 1'b1;
`endif
  endfunction

  task automatic take_snap(input int d);
    m_seg  = seg_n[d];
    m_mask = mask[d];
    m_brt  = brt;
  endtask

  // Predict the outputs registered on the coming edge, push to the scoreboard.
  task automatic model_edge();
    exp_t e;
    int   ph;
    int   d;
    e.ldsel = '0;
    e.sseg  = 8'hFF;
    e.tick  = 1'b0;
    if (rst || !en) begin
      active = 1'b0;
    end else if (!active) begin
      active = 1'b1;
      p      = 0;
      take_snap(0);
    end else begin
      ph = p % SCAN_DIV;
      d  = (p / SCAN_DIV) % N_DIG;
      if (ph >= GUARD && !m_mask && pwm_ok(ph - GUARD, m_brt)) begin
        e.ldsel = N_DIG'(1) << d;
        e.sseg  = m_seg;
      end
      e.tick = ((p % FRAME) == FRAME - 1);
      p++;
      if ((p % SCAN_DIV) == 0) take_snap((p / SCAN_DIV) % N_DIG);
    end
    sb_q.push_back(e);
  endtask

  // One clock: predict, clock, then compare on the falling edge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("ldsel", 32'(ldsel), 32'(e.ldsel));
      check("sseg_n", 32'(sseg_n), 32'(e.sseg));
      check("frame_tick", 32'(tick), 32'(e.tick));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int   lit_cnt;
    int   tick_cnt;
    int   lat;

`ifdef SSEG_PWM_EN
    tbl[0] = '{mask: 4'b0000, brt: 2'd3, exp_lit: 24, exp_tick: 1};
    tbl[1] = '{mask: 4'b0100, brt: 2'd3, exp_lit: 18, exp_tick: 1};
    tbl[2] = '{mask: 4'b0000, brt: 2'd1, exp_lit:  8, exp_tick: 1};
    tbl[3] = '{mask: 4'b0000, brt: 2'd0, exp_lit:  0, exp_tick: 1};
    tbl[4] = '{mask: 4'b0000, brt: 2'd2, exp_lit: 16, exp_tick: 1};
    tbl[5] = '{mask: 4'b1011, brt: 2'd2, exp_lit:  4, exp_tick: 1};
`else
    tbl[0] = '{mask: 4'b0000, brt: 2'd3, exp_lit: 24, exp_tick: 1};
    tbl[1] = '{mask: 4'b0100, brt: 2'd3, exp_lit: 18, exp_tick: 1};
    tbl[2] = '{mask: 4'b0000, brt: 2'd1, exp_lit: 24, exp_tick: 1};
    tbl[3] = '{mask: 4'b0000, brt: 2'd0, exp_lit: 24, exp_tick: 1};
    tbl[4] = '{mask: 4'b0000, brt: 2'd2, exp_lit: 24, exp_tick: 1};
    tbl[5] = '{mask: 4'b1011, brt: 2'd2, exp_lit:  6, exp_tick: 1};
`endif

    rst      = 1'b1;
    en       = 1'b0;
    seg_n[0] = 8'hC0;
    seg_n[1] = 8'hF9;
    seg_n[2] = 8'hA4;
    seg_n[3] = 8'hB0;
    mask     = '0;
    brt      = 2'd3;

    // Reset held, then idle with enable low.
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();

    // First lit cycle: cycle 1 is the sampling edge's cycle, lit in cycle GUARD+2.
    en  = 1'b1;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lat < 0 && ldsel != '0) lat = i + 1;
    end
    check("first_lit_cycle", 32'(lat), 32'(GUARD + 2));

    // Table: one full frame per brightness/mask setting, restarted cleanly.
    for (int r = 0; r < 6; r++) begin
      en = 1'b0;
      step();
      mask = tbl[r].mask;
      brt  = tbl[r].brt;
      en   = 1'b1;
      step();
      lit_cnt  = 0;
      tick_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        if (ldsel != '0) lit_cnt++;
        if (tick) tick_cnt++;
      end
      check($sformatf("row%0d_lit_cycles", r), 32'(lit_cnt), 32'(tbl[r].exp_lit));
      check($sformatf("row%0d_ticks", r), 32'(tick_cnt), 32'(tbl[r].exp_tick));
    end

    // Mid-slot change of digit 0: old pattern holds, new one shows next frame.
    en   = 1'b0;
    step();
    mask = '0;
    brt  = 2'd3;
    en   = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step();
      if (i == 5) seg_n[0] = 8'h99;
      if (i == 6) check("hold_old_seg", 32'(sseg_n), 32'h0000_00C0);
      if (i == 35) begin
        check("new_seg_next_frame", 32'(sseg_n), 32'h0000_0099);
        check("new_seg_ldsel", 32'(ldsel), 32'h0000_0001);
      end
    end
    seg_n[0] = 8'hC0;

    // Enable dropped mid-ON of digit 2, then re-enabled.
    en = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i < 21; i++) step();
    check("digit2_lit_before_drop", 32'(ldsel), 32'h0000_0004);
    en = 1'b0;
    step();
    check("drop_blank_ldsel", 32'(ldsel), 32'h0);
    check("drop_blank_sseg", 32'(sseg_n), 32'hFF);
    en  = 1'b1;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lat < 0 && ldsel != '0) begin
        lat = i + 1;
        check("restart_digit0", 32'(ldsel), 32'h0000_0001);
      end
    end
    check("restart_guard", 32'(lat), 32'(GUARD + 2));

    // Asynchronous reset mid-slot: outputs blank without waiting for an edge.
    for (int i = 0; i < 12; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ldsel", 32'(ldsel), 32'h0);
    check("async_rst_sseg", 32'(sseg_n), 32'hFF);
    check("async_rst_tick", 32'(tick), 32'h0);
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < FRAME + 1; i++) begin
      step();
      if (tick) tick_cnt++;
    end
    check("tick_after_reset", 32'(tick_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
